// File: rtl/t5_wbarb.sv
// t5_wbarb: round-robin arbiter merging the t5_rv32i instruction and data
// ports onto one shared memory port, with a watchdog for unanswered cycles.
module t5_wbarb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = 255
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    // instruction master
    input  logic [29:0]     iwb_adr,
    input  logic            iwb_stb,
    input  logic [3:0]      iwb_sel,
    input  logic            iwb_wre,
    output logic            iwb_ack,
    output logic [31:0]     iwb_dat,
    // data master
    input  logic [29:0]     dwb_adr,
    input  logic [XLEN-1:0] dwb_dto,
    input  logic [3:0]      dwb_sel,
    input  logic            dwb_stb,
    input  logic            dwb_wre,
    output logic            dwb_ack,
    output logic [XLEN-1:0] dwb_dti,
    // shared slave port
    output logic [29:0]     xwb_adr,
    output logic [XLEN-1:0] xwb_dto,
    output logic [3:0]      xwb_sel,
    output logic            xwb_stb,
    output logic            xwb_wre,
    input  logic            xwb_ack,
    input  logic [XLEN-1:0] xwb_dti,
    // watchdog abort pulse
    output logic            tmo_err
);

    localparam int unsigned CW = 16;
    localparam logic [31:0] ABORT_DAT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t          state;
    logic            last_d;    // 1: data master held the most recent grant
    logic [CW-1:0]   wd_cnt;
    logic            tmo_hit;
    logic            pick_d;
    logic            live;

    // Data wins unless the instruction side is also asking and data went last.
    assign pick_d = dwb_stb && (!iwb_stb || !last_d);

    // Watchdog expiry; a real ack in the same cycle takes precedence.
    assign tmo_hit = (TMO != 0) && (state != IDLE) && !xwb_ack
                     && (wd_cnt == CW'(TMO));

    // A reset cycle must never hand an ack to a master.
    assign live = !sys_rst;

    // Ack and read data pass straight through from the slave to the grantee.
    assign iwb_ack = live && (state == GNT_I) && (xwb_ack || tmo_hit);
    assign dwb_ack = live && (state == GNT_D) && (xwb_ack || tmo_hit);
    assign tmo_err = live && tmo_hit;
    assign iwb_dat = ((state == GNT_I) && tmo_hit) ? ABORT_DAT : 32'(xwb_dti);
    assign dwb_dti = ((state == GNT_D) && tmo_hit) ? XLEN'(ABORT_DAT) : xwb_dti;

    // Grant FSM, registered slave-side request fields and watchdog counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            xwb_adr <= '0;
            xwb_dto <= '0;
            xwb_sel <= '0;
            xwb_stb <= 1'b0;
            xwb_wre <= 1'b0;
            last_d  <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (dwb_stb || iwb_stb) begin
                        xwb_stb <= 1'b1;
                        if (pick_d) begin
                            state   <= GNT_D;
                            xwb_adr <= dwb_adr;
                            xwb_dto <= dwb_dto;
                            xwb_sel <= dwb_sel;
                            xwb_wre <= dwb_wre;
                        end else begin
                            state   <= GNT_I;
                            xwb_adr <= iwb_adr;
                            xwb_dto <= '0;
                            xwb_sel <= iwb_sel;
                            xwb_wre <= iwb_wre;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (xwb_ack || tmo_hit) begin
                        state   <= IDLE;
                        xwb_stb <= 1'b0;
                        xwb_wre <= 1'b0;
                        last_d  <= (state == GNT_D);
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    xwb_stb <= 1'b0;
                    xwb_wre <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed bench for t5_wbarb with a small programmable-latency slave.
module tb_t5_wbarb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TMO  = 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [29:0]     iwb_adr;
    logic            iwb_stb;
    logic [3:0]      iwb_sel;
    logic            iwb_wre;
    logic            iwb_ack;
    logic [31:0]     iwb_dat;
    logic [29:0]     dwb_adr;
    logic [XLEN-1:0] dwb_dto;
    logic [3:0]      dwb_sel;
    logic            dwb_stb;
    logic            dwb_wre;
    logic            dwb_ack;
    logic [XLEN-1:0] dwb_dti;
    logic [29:0]     xwb_adr;
    logic [XLEN-1:0] xwb_dto;
    logic [3:0]      xwb_sel;
    logic            xwb_stb;
    logic            xwb_wre;
    logic            xwb_ack;
    logic [XLEN-1:0] xwb_dti;
    logic            tmo_err;

    int checks = 0;
    int errors = 0;

    // slave model controls: slave_lat < 0 means never acknowledge
    int   slave_lat = 0;
    logic comb_ack  = 1'b0;
    logic spur      = 1'b0;
    logic ack_reg   = 1'b0;
    int   wcnt      = 0;

    t5_wbarb #(.XLEN(XLEN), .TMO(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_sel(iwb_sel),
        .iwb_wre(iwb_wre), .iwb_ack(iwb_ack), .iwb_dat(iwb_dat),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_ack(dwb_ack),
        .dwb_dti(dwb_dti),
        .xwb_adr(xwb_adr), .xwb_dto(xwb_dto), .xwb_sel(xwb_sel),
        .xwb_stb(xwb_stb), .xwb_wre(xwb_wre), .xwb_ack(xwb_ack),
        .xwb_dti(xwb_dti), .tmo_err(tmo_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Slave: acks slave_lat cycles after first seeing stb, one-cycle pulse.
    always @(posedge sys_clk) begin
        if (xwb_stb && !xwb_ack && slave_lat >= 0) begin
            if (wcnt == slave_lat) begin
                ack_reg <= 1'b1;
                wcnt    <= 0;
            end else begin
                ack_reg <= 1'b0;
                wcnt    <= wcnt + 1;
            end
        end else begin
            ack_reg <= 1'b0;
            wcnt    <= 0;
        end
    end

    assign xwb_ack = spur | (comb_ack ? xwb_stb : ack_reg);

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        iwb_adr = '0; iwb_stb = 1'b0; iwb_sel = '0; iwb_wre = 1'b0;
        dwb_adr = '0; dwb_dto = '0; dwb_sel = '0; dwb_stb = 1'b0; dwb_wre = 1'b0;
        xwb_dti = '0;

        // reset state
        tick(); tick();
        chk("rst_stb", 32'(xwb_stb), 32'd0);
        chk("rst_adr", 32'(xwb_adr), 32'd0);
        chk("rst_dto", xwb_dto, 32'd0);
        chk("rst_iack", 32'(iwb_ack), 32'd0);
        chk("rst_dack", 32'(dwb_ack), 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);

        // instruction read, slave acks two cycles after stb
        sys_rst = 1'b0;
        slave_lat = 1; xwb_dti = 32'h00000013;
        iwb_stb = 1'b1; iwb_adr = 30'h10; iwb_sel = 4'hF;
        tick();
        chk("i_stb", 32'(xwb_stb), 32'd1);
        chk("i_adr", 32'(xwb_adr), 32'h10);
        chk("i_dto", xwb_dto, 32'd0);
        chk("i_ack_early", 32'(iwb_ack), 32'd0);
        tick();
        chk("i_ack_wait", 32'(iwb_ack), 32'd0);
        tick();
        chk("i_ack", 32'(iwb_ack), 32'd1);
        chk("i_dat", iwb_dat, 32'h13);
        chk("i_dack", 32'(dwb_ack), 32'd0);
        chk("i_tmo", 32'(tmo_err), 32'd0);
        iwb_stb = 1'b0;
        tick();
        chk("i_idle_stb", 32'(xwb_stb), 32'd0);
        chk("i_idle_ack", 32'(iwb_ack), 32'd0);

        // continuous dual requests, zero-wait slave: D, I, D, I
        comb_ack = 1'b1;
        iwb_stb = 1'b1; iwb_adr = 30'h20;
        dwb_stb = 1'b1; dwb_adr = 30'h40;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_stb", 32'(xwb_stb), 32'd1);
            chk("rr_adr", 32'(xwb_adr), (g % 2 == 0) ? 32'h40 : 32'h20);
            chk("rr_dack", 32'(dwb_ack), (g % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_iack", 32'(iwb_ack), (g % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("rr_gap", 32'(xwb_stb), 32'd0);
        end
        iwb_stb = 1'b0; dwb_stb = 1'b0; comb_ack = 1'b0;
        tick();

        // data write held stable until ack
        slave_lat = 2;
        dwb_stb = 1'b1; dwb_adr = 30'h800; dwb_sel = 4'h3;
        dwb_dto = 32'hCAFEBABE; dwb_wre = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("w_adr", 32'(xwb_adr), 32'h800);
            chk("w_sel", 32'(xwb_sel), 32'h3);
            chk("w_dto", xwb_dto, 32'hCAFEBABE);
            chk("w_wre", 32'(xwb_wre), 32'd1);
            chk("w_stb", 32'(xwb_stb), 32'd1);
            chk("w_dack_wait", 32'(dwb_ack), 32'd0);
        end
        tick();
        chk("w_dack", 32'(dwb_ack), 32'd1);
        chk("w_adr_ack", 32'(xwb_adr), 32'h800);
        dwb_stb = 1'b0; dwb_wre = 1'b0;
        tick();
        chk("w_dack_once", 32'(dwb_ack), 32'd0);
        chk("w_idle_stb", 32'(xwb_stb), 32'd0);

        // slave never acks: watchdog fires 8 cycles after stb rose
        slave_lat = -1;
        iwb_stb = 1'b1; iwb_adr = 30'h30;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t_iack_wait", 32'(iwb_ack), 32'd0);
            chk("t_tmo_wait", 32'(tmo_err), 32'd0);
        end
        tick();
        chk("t_iack", 32'(iwb_ack), 32'd1);
        chk("t_tmo", 32'(tmo_err), 32'd1);
        chk("t_dat", iwb_dat, 32'hDEADBEEF);
        chk("t_dack", 32'(dwb_ack), 32'd0);
        iwb_stb = 1'b0;
        tick();
        chk("t_idle_stb", 32'(xwb_stb), 32'd0);
        chk("t_tmo_off", 32'(tmo_err), 32'd0);

        // ack lands in the same cycle the count reaches the limit
        slave_lat = 7; xwb_dti = 32'h12345678;
        iwb_stb = 1'b1; iwb_adr = 30'h34;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("c_iack_wait", 32'(iwb_ack), 32'd0);
        end
        tick();
        chk("c_iack", 32'(iwb_ack), 32'd1);
        chk("c_dat", iwb_dat, 32'h12345678);
        chk("c_tmo", 32'(tmo_err), 32'd0);
        iwb_stb = 1'b0;
        tick();
        chk("c_idle_stb", 32'(xwb_stb), 32'd0);

        // spurious ack while idle
        spur = 1'b1;
        #1;
        chk("s_iack", 32'(iwb_ack), 32'd0);
        chk("s_dack", 32'(dwb_ack), 32'd0);
        tick();
        spur = 1'b0;
        #1;
        chk("s_stb", 32'(xwb_stb), 32'd0);
        chk("s_iack2", 32'(iwb_ack), 32'd0);

        // a completed D grant leaves data as last grantee
        comb_ack = 1'b1;
        dwb_stb = 1'b1; dwb_adr = 30'h50;
        tick();
        chk("p_dack", 32'(dwb_ack), 32'd1);
        tick();
        chk("p_gap", 32'(xwb_stb), 32'd0);

        // reset in the middle of a D grant
        comb_ack = 1'b0; slave_lat = -1;
        tick();
        chk("r_stb_pre", 32'(xwb_stb), 32'd1);
        chk("r_adr_pre", 32'(xwb_adr), 32'h50);
        sys_rst = 1'b1; spur = 1'b1;
        #1;
        chk("r_dack_in_rst", 32'(dwb_ack), 32'd0);
        tick();
        chk("r_stb", 32'(xwb_stb), 32'd0);
        chk("r_dack", 32'(dwb_ack), 32'd0);
        chk("r_adr", 32'(xwb_adr), 32'd0);
        sys_rst = 1'b0; spur = 1'b0;
        iwb_stb = 1'b1; iwb_adr = 30'h60;
        tick();
        chk("r_first_stb", 32'(xwb_stb), 32'd1);
        chk("r_first_adr", 32'(xwb_adr), 32'h50);
        iwb_stb = 1'b0; dwb_stb = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/t5_wbarb.md
Name: t5_wbarb

Overview:
- Two-master to one-slave bus arbiter for the t5_rv32i core.
- Merges the instruction port (iwb_*) and the data port (dwb_*) onto a single shared memory port (xwb_*), so the core can run against one unified memory.
- Grants one master at a time using round-robin on contention.
- A watchdog aborts any slave cycle that is never acknowledged.

Parameters:
- XLEN, 32: data width of the data and shared buses.
- TMO, 255: watchdog limit in cycles from xwb_stb assertion; valid range 1..65535. 0 disables the watchdog.

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- iwb_adr  in  30  instruction word address [31:2].
- iwb_stb  in  1  instruction request.
- iwb_sel  in  4  instruction byte selects.
- iwb_wre  in  1  instruction write enable (normally 0).
- iwb_ack  out  1  instruction acknowledge.
- iwb_dat  out  32  instruction read data.
- dwb_adr  in  30  data word address [31:2].
- dwb_dto  in  XLEN  data write data.
- dwb_sel  in  4  data byte selects.
- dwb_stb  in  1  data request.
- dwb_wre  in  1  data write enable.
- dwb_ack  out  1  data acknowledge.
- dwb_dti  out  XLEN  data read data.
- xwb_adr  out  30  shared address.
- xwb_dto  out  XLEN  shared write data.
- xwb_sel  out  4  shared byte selects.
- xwb_stb  out  1  shared strobe.
- xwb_wre  out  1  shared write enable.
- xwb_ack  in  1  shared acknowledge (single-cycle pulse).
- xwb_dti  in  XLEN  shared read data.
- tmo_err  out  1  one-cycle pulse when the watchdog aborts a cycle.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - xwb_stb, xwb_wre, iwb_ack, dwb_ack and tmo_err are 0.
  - xwb_adr, xwb_sel and xwb_dto are 0.
  - Last-grant bit is set to I, so data wins the first tie.
  - Watchdog count is 0.
  - Reset mid-cycle drops xwb_stb the next edge with no ack to either master.
- FSM has three states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only dwb_stb high: go to GNT_D.
  - Only iwb_stb high: go to GNT_I.
  - Both high: grant the master that was not granted last.
  - Neither high: stay in IDLE.
- On entering a grant state:
  - xwb_adr/sel/wre/dto are registered from the granted master and xwb_stb=1.
  - This gives 1 cycle of latency from master stb to xwb_stb.
  - For an I grant, xwb_dto = 0.
  - Request fields stay registered (held stable) for the whole grant. Masters must hold stb/adr stable until ack.
- GNT_x:
  - Ack and read data pass through combinationally: x_ack = xwb_ack, and the read data is xwb_dti. Zero added return latency.
  - The non-granted ack is 0.
  - On xwb_ack: next state IDLE, xwb_stb=0 next cycle, last-grant bit = x.
  - The mandatory single IDLE cycle between grants guarantees a stb deassertion the slave can see.
- Master drops stb while granted (protocol violation): the cycle continues until ack or timeout.
  - An ack arriving after stb dropped is still forwarded.
- Watchdog:
  - Counter clears on entering a grant and increments each cycle in a grant without xwb_ack.
  - When the count reaches TMO with no ack, the aborted cycle ends:
    - pulse the granted master's ack with read data forced to 32'hDEADBEEF;
    - pulse tmo_err;
    - go to IDLE;
    - update the last-grant bit.
  - Counter width is 16 bits and saturates, no wrap.
- xwb_ack while IDLE (spurious) is ignored; no master ack results.
- xwb_ack arriving in the same cycle as the timeout: treated as a normal ack, with no tmo_err and real data.
- Throughput: each transaction costs 1 + slave latency + 1 IDLE cycle.
- Under continuous dual requests, grants strictly alternate D, I, D, I.

Test Plan:
- Reset, then iwb_stb=1, iwb_adr=0x10, slave acks 2 cycles after xwb_stb with xwb_dti=0x00000013 -> xwb_adr=0x10 one cycle after stb; iwb_ack=1 with iwb_dat=0x13 in the xwb_ack cycle; dwb_ack stays 0.
- Both stb high from reset with zero-wait slave -> grant order D, I, D, I; xwb_stb low for exactly one cycle between grants.
- Data write: dwb_adr=0x800, dwb_sel=4'h3, dwb_dto=0xCAFEBABE, dwb_wre=1 -> xwb_* carries identical fields, held stable until ack; dwb_ack pulses once.
- Slave never acks, TMO=8 -> iwb_ack and tmo_err pulse together 8 cycles after xwb_stb rose; iwb_dat=0xDEADBEEF; FSM back in IDLE.
- xwb_ack in the same cycle the count hits TMO -> normal ack with real data and tmo_err=0. Spurious xwb_ack in IDLE -> no master ack.
- sys_rst asserted mid GNT_D -> xwb_stb=0 the next cycle, no dwb_ack; after release with both requesting, D is granted first.
